// File: rtl/scan_pos_gen_pkg.sv
// Shared types and constants for the scan position generator.
//   scan_state_t : FSM state encoding (IDLE, SCAN, DONE)
//   scan_mode_t  : walk order (RASTER, SERPENTINE)
//   DIR_*        : next_dir codes presented alongside each position
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    typedef enum logic {
        RASTER     = 1'b0,
        SERPENTINE = 1'b1
    } scan_mode_t;

    localparam logic [1:0] DIR_XP = 2'b00;  // next move x+
    localparam logic [1:0] DIR_XM = 2'b01;  // next move x-
    localparam logic [1:0] DIR_YR = 2'b10;  // row step after a rightward row
    localparam logic [1:0] DIR_YL = 2'b11;  // row step after a leftward row

endpackage

// File: rtl/scan_pos_gen_if.sv
// Position stream from the generator to the window-fetch consumer.
//   pos_valid/pos_ready : handshake
//   curr_x/curr_y       : position payload
//   next_dir            : move taken on the next handshake
//   first_pos/last_pos  : scan boundary markers
//
// Handshake: a transfer happens on a rising clk edge where pos_valid and
// pos_ready are both 1. While pos_valid is 1 and no transfer has happened,
// the producer holds the payload stable and does not drop pos_valid (except
// on abort/reset). pos_ready may depend combinationally on nothing from the
// producer other than pos_valid.
interface scan_pos_gen_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          pos_valid;
    logic          pos_ready;
    logic [XW-1:0] curr_x;
    logic [YW-1:0] curr_y;
    logic [1:0]    next_dir;
    logic          first_pos;
    logic          last_pos;

    modport master (
        output pos_valid, curr_x, curr_y, next_dir, first_pos, last_pos,
        input  pos_ready
    );

    modport slave (
        input  pos_valid, curr_x, curr_y, next_dir, first_pos, last_pos,
        output pos_ready
    );
endinterface

// File: rtl/scan_pos_gen_axis_step.sv
// One coordinate axis of the scan walker.
//   lo, hi    : inclusive bounds of the axis
//   step      : stride, >= 1
//   dir       : 0 = counting up, 1 = counting down
//   load      : value <= lo
//   advance   : value moves one stride in dir (ignored when load is set)
//   value     : current coordinate
//   at_limit  : one more stride in dir would leave [lo, hi]
module scan_axis_step #(
    parameter int W  = 10,
    parameter int SW = 3
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [W-1:0]  lo,
    input  logic [W-1:0]  hi,
    input  logic [SW-1:0] step,
    input  logic          dir,
    input  logic          load,
    input  logic          advance,
    output logic [W-1:0]  value,
    output logic          at_limit
);
    logic [W:0] step_ext;
    logic [W:0] val_ext;

    // Limit compares run one bit wider than the axis so value+step near the
    // top of the range cannot wrap and falsely look in-bounds.
    always_comb begin
        step_ext = (W+1)'(step);
        val_ext  = {1'b0, value};
        if (dir) at_limit = val_ext < ({1'b0, lo} + step_ext);
        else     at_limit = (val_ext + step_ext) > {1'b0, hi};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value <= '0;
        end else if (load) begin
            value <= lo;
        end else if (advance) begin
            // Only advanced when !at_limit, so the down step never underflows.
            if (dir) value <= value - W'(step);
            else     value <= value + W'(step);
        end
    end
endmodule

// File: rtl/scan_pos_gen.sv
// ROI scan position generator: walks [x_start..x_end] x [y_start..y_end]
// with programmable strides in raster or serpentine order and offers each
// position on the pos interface.
//   clk, n_rst          : clock, async active-low reset
//   start, abort        : begin scan (IDLE only) / cancel scan (SCAN only)
//   mode, x_*, y_*      : scan configuration, latched on accepted start
//   pos                 : position stream (master side)
//   busy, done, cfg_err : status; done and cfg_err are one-cycle pulses
//   state_dbg           : FSM state for observation
module scan_pos_gen
    import scan_pkg::*;
#(
    parameter int X_MAX  = 640,
    parameter int Y_MAX  = 480,
    parameter int STEP_W = 3,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [XW-1:0]     x_start,
    input  logic [XW-1:0]     x_end,
    input  logic [YW-1:0]     y_start,
    input  logic [YW-1:0]     y_end,
    input  logic [STEP_W-1:0] x_step,
    input  logic [STEP_W-1:0] y_step,
    scan_pos_gen_if.master    pos,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [1:0]        state_dbg
);
    localparam logic [XW:0] X_LIM = (XW+1)'(X_MAX);
    localparam logic [YW:0] Y_LIM = (YW+1)'(Y_MAX);

    scan_state_t       state;
    scan_mode_t        cfg_mode;
    logic [XW-1:0]     cfg_xs, cfg_xe;
    logic [YW-1:0]     cfg_ys, cfg_ye;
    logic [STEP_W-1:0] cfg_xst, cfg_yst;
    logic              dir_left, first_q, cfg_err_q;

    logic              in_idle, in_scan, cfg_bad, start_ok, hs;
    logic              x_row_end, y_final, last;
    logic [XW-1:0]     x_lo, x_hi, x_val;
    logic [YW-1:0]     y_lo, y_hi, y_val;
    logic [STEP_W-1:0] x_st, y_st;
    logic              x_load, x_adv, y_load, y_adv;

    assign in_idle = (state == IDLE);
    assign in_scan = (state == SCAN);

    assign cfg_bad = (x_start > x_end) || (y_start > y_end)
                  || ({1'b0, x_end} >= X_LIM) || ({1'b0, y_end} >= Y_LIM)
                  || (x_step == '0) || (y_step == '0);

    assign start_ok = in_idle && start && !cfg_bad;
    // abort takes priority: a cancelled cycle never counts as a transfer.
    assign hs       = in_scan && pos.pos_ready && !abort;
    assign last     = x_row_end && y_final;

    // In IDLE the axes load straight from the inputs on the accepting edge;
    // afterwards they work from the latched copy.
    assign x_lo = in_idle ? x_start : cfg_xs;
    assign x_hi = in_idle ? x_end   : cfg_xe;
    assign x_st = in_idle ? x_step  : cfg_xst;
    assign y_lo = in_idle ? y_start : cfg_ys;
    assign y_hi = in_idle ? y_end   : cfg_ye;
    assign y_st = in_idle ? y_step  : cfg_yst;

    // Raster rewinds x at each row end; serpentine leaves x where it is.
    assign x_load = start_ok || (hs && x_row_end && !y_final && cfg_mode == RASTER);
    assign x_adv  = hs && !x_row_end;
    assign y_load = start_ok;
    assign y_adv  = hs && x_row_end && !y_final;

    scan_axis_step #(.W(XW), .SW(STEP_W)) u_x_axis (
        .clk(clk), .n_rst(n_rst), .lo(x_lo), .hi(x_hi), .step(x_st),
        .dir(dir_left), .load(x_load), .advance(x_adv),
        .value(x_val), .at_limit(x_row_end)
    );

    scan_axis_step #(.W(YW), .SW(STEP_W)) u_y_axis (
        .clk(clk), .n_rst(n_rst), .lo(y_lo), .hi(y_hi), .step(y_st),
        .dir(1'b0), .load(y_load), .advance(y_adv),
        .value(y_val), .at_limit(y_final)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            cfg_mode  <= RASTER;
            cfg_xs    <= '0;
            cfg_xe    <= '0;
            cfg_ys    <= '0;
            cfg_ye    <= '0;
            cfg_xst   <= '0;
            cfg_yst   <= '0;
            dir_left  <= 1'b0;
            first_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err_q <= 1'b1;
                        end else begin
                            state    <= SCAN;
                            cfg_mode <= scan_mode_t'(mode);
                            cfg_xs   <= x_start;
                            cfg_xe   <= x_end;
                            cfg_ys   <= y_start;
                            cfg_ye   <= y_end;
                            cfg_xst  <= x_step;
                            cfg_yst  <= y_step;
                            dir_left <= 1'b0;
                            first_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (hs) begin
                        first_q <= 1'b0;
                        if (last)
                            state <= DONE;
                        else if (x_row_end && cfg_mode == SERPENTINE)
                            dir_left <= !dir_left;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        pos.next_dir = DIR_XP;
        if (in_scan && !last) begin
            if (x_row_end) pos.next_dir = dir_left ? DIR_YL : DIR_YR;
            else           pos.next_dir = dir_left ? DIR_XM : DIR_XP;
        end
    end

    assign pos.pos_valid = in_scan;
    assign pos.curr_x    = x_val;
    assign pos.curr_y    = y_val;
    assign pos.first_pos = in_scan && first_q;
    assign pos.last_pos  = in_scan && last;
    assign busy          = in_scan;
    assign done          = (state == DONE);
    assign cfg_err       = cfg_err_q;
    assign state_dbg     = state;
endmodule

// File: doc/scan_pos_gen.md
# scan_pos_gen

Parametrised pixel-coordinate generator that walks a programmable region of interest (ROI) in raster or serpentine order, with programmable X/Y step. Coordinates are delivered under a valid/ready handshake. It sits between the frame controller and the FAST window fetch / corner-score pipeline. It adds ROI offsets, subsampling stride, backpressure, abort and configuration checking to the earlier fixed full-frame serpentine walker.

## Interface
Parameters:
- X_MAX, 640: frame width in pixels, ≥2; XW = $clog2(X_MAX)
- Y_MAX, 480: frame height in pixels, ≥2; YW = $clog2(Y_MAX)
- STEP_W, 3: width of the step inputs

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin scan; sampled only in IDLE
- abort  in  1  synchronous scan cancel
- mode  in  1  0 = raster, 1 = serpentine
- x_start, x_end  in  XW  inclusive ROI column bounds
- y_start, y_end  in  YW  inclusive ROI row bounds
- x_step  in  STEP_W  column stride, ≥1
- y_step  in  STEP_W  row stride, ≥1
- pos_valid  out  1  curr_x/curr_y hold a valid position
- pos_ready  in  1  consumer accepts the position
- curr_x  out  XW  current column
- curr_y  out  YW  current row
- next_dir  out  2  move taken on the next handshake: 00 = x+, 01 = x−, 10 = y after a rightward row, 11 = y after a leftward row; 00 when last_pos = 1
- first_pos  out  1  current position is the first of the scan
- last_pos  out  1  current position is the final one
- busy  out  1  FSM in SCAN
- done  out  1  one-cycle pulse after the last handshake
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- FSM states: IDLE → SCAN → DONE → IDLE.
- IDLE, start = 1:
  - All config inputs are latched. Config is ignored at every other time.
  - Config is invalid if any of: x_start > x_end, y_start > y_end, x_end ≥ X_MAX, y_end ≥ Y_MAX, x_step = 0, y_step = 0.
  - Invalid: cfg_err pulses and the FSM stays in IDLE.
  - Valid: position = (x_start, y_start), direction = rightward, go to SCAN.
- SCAN: pos_valid = 1. A handshake (pos_valid & pos_ready) advances the position.
- Row-end test:
  - Rightward: x + x_step > x_end.
  - Leftward: x < x_start + x_step.
  - All sums are computed at XW+1 / YW+1 bits; no wrap-around.
- Final-row test: y + y_step > y_end.
- Raster mode:
  - Not at row end: x += x_step.
  - At row end: x = x_start, y += y_step.
- Serpentine mode:
  - Not at row end: x ± x_step.
  - At row end: y += y_step, x unchanged, direction flips.
  - The leftward row therefore revisits the columns of the rightward row in reverse, e.g. x_start 1, x_end 6, step 2 gives 1,3,5 then 5,3,1.
- last_pos = row end & final row. A handshake on last_pos moves the FSM to DONE.
- DONE: lasts one cycle; done = 1, pos_valid = 0, busy = 0. Then IDLE.
- abort in SCAN: IDLE on the next edge; no done pulse; pending position dropped. abort outside SCAN has no effect.
- start while not in IDLE is ignored. abort and handshake in the same cycle: abort wins.

## Timing
- Reset values: pos_valid 0, busy 0, done 0, cfg_err 0, first_pos 0, last_pos 0, curr_x 0, curr_y 0, next_dir 00; FSM in IDLE.
- start accepted at edge N: pos_valid, busy and first_pos are high from cycle N+1. cfg_err for a rejected start is also high in cycle N+1.
- Throughput is one position per cycle while pos_ready = 1.
- Backpressure: while pos_valid & !pos_ready, curr_x, curr_y, next_dir, first_pos and last_pos are stable.
- first_pos clears after the first handshake.
- next_dir, last_pos and first_pos are registered-state derived and valid in the same cycle as the position.
- Last handshake at edge M: done in cycle M+1; a new start is accepted from edge M+2.
- Reset mid-scan returns the block to IDLE immediately, all outputs at reset values.

## Structure
- scan_pkg holds:
  - scan_state_t enum {IDLE, SCAN, DONE}
  - scan_mode_t enum {RASTER, SERPENTINE}
  - localparams DIR_XP = 2'b00, DIR_XM = 2'b01, DIR_YR = 2'b10, DIR_YL = 2'b11
- One sub-module, scan_axis_step, parametrised on width:
  - Inputs: lo, hi, step, dir, load, advance.
  - Outputs: value, at_limit (overflow-safe).
  - Instantiated once for X (bidirectional) and once for Y (up only).
- The top level holds the FSM, config latch, direction register and output decode.

## Test plan
- Raster, ROI x 0..3, y 0..2, steps 1, ready held 1 → 12 positions (0,0),(1,0)…(3,2) on consecutive cycles; last_pos only on (3,2); done one cycle after.
- Serpentine, x 0..3, y 0..1 → (0,0),(1,0),(2,0),(3,0),(3,1),(2,1),(1,1),(0,1); next_dir = 10 at (3,0), 01 on (3,1)…(1,1), 00 at (0,1).
- Serpentine, x 1..6 step 2, y 0..4 step 2 → rows 0, 2, 4 with x sequences 1,3,5 / 5,3,1 / 1,3,5; 9 positions, then done.
- Backpressure: pos_ready low for 3 cycles at raster position (2,0) → outputs frozen; next accepted position is (3,0); no position skipped or repeated.
- Errors:
  - start with x_start 5, x_end 2 → cfg_err pulse, busy stays 0.
  - start with y_step 0 → same.
  - abort at (1,1) → IDLE next cycle, no done.
  - n_rst low mid-scan → all outputs at reset values.
- Single-pixel ROI (4,7)-(4,7) → one position with first_pos = last_pos = 1, next_dir 00, done after the handshake; start held high during DONE is ignored.
